alu_pipe: RTL

//  Parametrised, pipelined W-bit ALU with a valid/ready handshake on input and output.

---
 rtl/alu_pipe_pkg.sv | 17 +
 rtl/alu_pipe_core.sv | 34 +++
 rtl/alu_pipe.sv | 75 +++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcodes and flag bit positions shared by the ALU pipeline
package alu_pipe_pkg;
  typedef enum logic [2:0] {
    OP_ADC = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_SBC = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_SHR = 3'd7
  } op_e;
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;
endpackage

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: combinational result, flags and carry-update strobe for one op
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] y_o,
  output logic [3:0]   flags_o,
  output logic         carry_upd_o
);
  logic [W-1:0] bb;
  logic [W:0]   s;
  logic         arith;
  // subtracts invert B; op[2]=0 selects the adder, op[2]=1 the logic/shift unit
  always_comb begin
    arith = ~op_i[2];
    bb = op_i[1] ? ~b_i : b_i;
    s = {1'b0, a_i} + {1'b0, bb} + {{W{1'b0}}, cin_i};
    y_o = arith ? s[W-1:0] :
          op_i == OP_AND ? a_i & b_i :
          op_i == OP_OR  ? a_i | b_i :
          op_i == OP_XOR ? a_i ^ b_i : {1'b0, a_i[W-1:1]};
    flags_o = '0;
    flags_o[FLG_Z] = y_o == '0;
    flags_o[FLG_N] = y_o[W-1];
    flags_o[FLG_C] = arith ? s[W] : op_i == OP_SHR ? a_i[0] : 1'b0;
    flags_o[FLG_V] = arith & (a_i[W-1] == bb[W-1]) & (y_o[W-1] != a_i[W-1]);
    carry_upd_o = arith | (op_i == OP_SHR);
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU with stored carry and valid/ready back-pressure
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic [3:0]   flags,
  output logic         carry_q
);
  logic [W-1:0]      cy;
  logic [3:0]        cf;
  logic              cu, cin, carry_d;
  logic [STAGES-1:0] adv;
  logic              v_q [STAGES];
  logic              v_d [STAGES];
  logic [W-1:0]      y_q [STAGES];
  logic [W-1:0]      y_d [STAGES];
  logic [3:0]        f_q [STAGES];
  logic [3:0]        f_d [STAGES];
  assign cin = op == OP_ADD ? ci : op == OP_SUB ? 1'b1 : carry_q;
  alu_pipe_core #(.W(W)) u_core (
    .op_i(op), .a_i(a), .b_i(b), .cin_i(cin),
    .y_o(cy), .flags_o(cf), .carry_upd_o(cu)
  );
  assign in_ready = adv[0];
  assign carry_d = (in_valid & in_ready & cu) ? cf[FLG_C] : carry_q;
  // carry follows every accepted arithmetic/shift op so chained ADC/SBC need no stall
  always_ff @(posedge clk) begin
    if (rst) carry_q <= 1'b0;
    else carry_q <= carry_d;
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_s
    if (k == 0) begin : g_h
      assign v_d[k] = in_valid;
      assign y_d[k] = cy;
      assign f_d[k] = cf;
    end else begin : g_t
      assign v_d[k] = v_q[k-1];
      assign y_d[k] = y_q[k-1];
      assign f_d[k] = f_q[k-1];
    end
    if (k == STAGES - 1) begin : g_l
      assign adv[k] = ~v_q[k] | out_ready;
    end else begin : g_m
      assign adv[k] = ~v_q[k] | adv[k+1];
    end
    // slot loads from its predecessor whenever it is free or its contents move on
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q[k] <= 1'b0;
        y_q[k] <= '0;
        f_q[k] <= '0;
      end else if (adv[k]) begin
        v_q[k] <= v_d[k];
        y_q[k] <= y_d[k];
        f_q[k] <= f_d[k];
      end
    end
  end
  assign out_valid = v_q[STAGES-1];
  assign y = y_q[STAGES-1];
  assign flags = f_q[STAGES-1];
endmodule
